// File: rtl/ovr_i_monitor_if.sv
//==============================================================================
// Module      : ovr_i_monitor_if
// Description : Signal bundle between driver-chip fault pins, PWM timing and
//               the over-current monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ovr_i_monitor_if;
  logic       PWM_synch;
  logic       OVR_I_lft;
  logic       OVR_I_rght;
  logic       clr_trip;
  logic       ovr_I_blank;
  logic       ovr_I_shtdwn;
  logic [1:0] trip_src;
  logic [7:0] trip_cnt;

  modport master (
    output PWM_synch, OVR_I_lft, OVR_I_rght, clr_trip,
    input  ovr_I_blank, ovr_I_shtdwn, trip_src, trip_cnt
  );

  modport slave (
    input  PWM_synch, OVR_I_lft, OVR_I_rght, clr_trip,
    output ovr_I_blank, ovr_I_shtdwn, trip_src, trip_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ovr_i_monitor.sv
//==============================================================================
// Module      : ovr_i_monitor
// Description : Over-current monitor: blanks switching spikes after each PWM
//               period start, debounces real faults and latches a shutdown.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ovr_i_monitor #(
  parameter int unsigned BLANK_CYCLES = 128,
  parameter int unsigned DEBOUNCE     = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ovr_i_monitor_if.slave    bus
);

  localparam logic [10:0] C_BLANK_LOAD = 11'(BLANK_CYCLES);
  localparam logic [7:0]  C_DEB_LAST   = 8'(DEBOUNCE - 1);

  typedef enum logic [0:0] {
    ARMED   = 1'b0,
    TRIPPED = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_lft_s1, r_lft_s;
  logic        r_rght_s1, r_rght_s;
  logic [10:0] r_blank_cnt;
  logic        r_blank;
  logic [7:0]  r_deb_cnt;
  logic        r_shtdwn;
  logic [1:0]  r_trip_src;
  logic [7:0]  r_trip_cnt;

  logic [10:0] w_blank_nxt;
  logic        w_qual;

  always_comb begin
    w_blank_nxt = r_blank_cnt;
    if (bus.PWM_synch)
      w_blank_nxt = C_BLANK_LOAD;
    else if (r_blank_cnt != 11'd0)
      w_blank_nxt = r_blank_cnt - 11'd1;
  end

  // Uses the registered blank flag, so a PWM_synch on the trip edge cannot stop the trip.
  assign w_qual = (r_lft_s | r_rght_s) & ~r_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARMED;
      r_lft_s1    <= 1'b0;
      r_lft_s     <= 1'b0;
      r_rght_s1   <= 1'b0;
      r_rght_s    <= 1'b0;
      r_blank_cnt <= C_BLANK_LOAD;
      r_blank     <= 1'b1;
      r_deb_cnt   <= 8'd0;
      r_shtdwn    <= 1'b0;
      r_trip_src  <= 2'b00;
      r_trip_cnt  <= 8'd0;
    end else begin
      r_lft_s1    <= bus.OVR_I_lft;
      r_lft_s     <= r_lft_s1;
      r_rght_s1   <= bus.OVR_I_rght;
      r_rght_s    <= r_rght_s1;
      r_blank_cnt <= w_blank_nxt;
      r_blank     <= (w_blank_nxt != 11'd0);

      case (r_state)
        ARMED: begin
          if (w_qual && (r_deb_cnt == C_DEB_LAST)) begin
            r_state    <= TRIPPED;
            r_shtdwn   <= 1'b1;
            r_trip_src <= {r_lft_s, r_rght_s};
            r_deb_cnt  <= 8'd0;
            if (r_trip_cnt != 8'hFF)
              r_trip_cnt <= r_trip_cnt + 8'd1;
          end else if (w_qual) begin
            r_deb_cnt <= r_deb_cnt + 8'd1;
          end else begin
            r_deb_cnt <= 8'd0;
          end
        end
        TRIPPED: begin
          // A clear while a fault is still present is dropped, not queued.
          if (bus.clr_trip && !r_lft_s && !r_rght_s) begin
            r_state    <= ARMED;
            r_shtdwn   <= 1'b0;
            r_deb_cnt  <= 8'd0;
            r_trip_src <= 2'b00;
          end
        end
        default: r_state <= ARMED;
      endcase
    end
  end

  assign bus.ovr_I_blank  = r_blank;
  assign bus.ovr_I_shtdwn = r_shtdwn;
  assign bus.trip_src     = r_trip_src;
  assign bus.trip_cnt     = r_trip_cnt;

endmodule

`default_nettype wire
